// File: rtl/mem_pkg.sv
// Shared definitions for the accumulator datapath memory interface.
// Used by mem_responder and by the requesting control FSM.
package mem_pkg;

    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 6;
    localparam int DEPTH            = 32;
    localparam int READ_LAT_DEFAULT = 1;
    localparam int IDX_W            = $clog2(DEPTH);

    // Responder FSM encoding; CLEAR is only reachable with the power-up sweep.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Addresses DEPTH..2^ADDR_W-1 decode to no storage.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control FSM (master) and the
// memory responder (slave).
interface mem_responder_if;

    logic [mem_pkg::ADDR_W-1:0] Address;
    logic                       ReadEnable;
    logic                       WriteEnable;
    logic [mem_pkg::DATA_W-1:0] DataIN;
    logic [mem_pkg::DATA_W-1:0] DataOut;
    logic                       DataValid;
    logic                       Busy;
    logic                       AccessError;

    modport master (
        output Address, ReadEnable, WriteEnable, DataIN,
        input  DataOut, DataValid, Busy, AccessError
    );

    modport slave (
        input  Address, ReadEnable, WriteEnable, DataIN,
        output DataOut, DataValid, Busy, AccessError
    );

endinterface

// File: rtl/mem_read_pipe.sv
// READ_LAT-deep {valid, data} delay line for read responses. The final
// stage holds its data between responses; valid bits flush on reset.
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              last_valid;
    logic [DATA_W-1:0] last_data;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("mem_read_pipe: READ_LAT must be in 1..4");
    end

    if (READ_LAT == 1) begin : g_direct
        assign last_valid = in_valid;
        assign last_data  = in_data;
    end else begin : g_stages
        logic [READ_LAT-2:0] stage_valid;
        logic [DATA_W-1:0]   stage_data [READ_LAT-1];

        // Shift the valid bits; reset discards every in-flight read.
        always_ff @(posedge Clock) begin
            if (!Reset) begin
                stage_valid <= '0;
            end else begin
                stage_valid[0] <= in_valid;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                end
            end
        end

        // Shift the data alongside; it is only consumed when its valid bit is set.
        always_ff @(posedge Clock) begin
            // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
            stage_data[0] <= in_data;
            for (int i = 1; i < READ_LAT - 1; i++) begin
                stage_data[i] <= stage_data[i-1];
            end
        end

        assign last_valid = stage_valid[READ_LAT-2];
        assign last_data  = stage_data[READ_LAT-2];
    end

    // Output stage: strobe for one cycle, hold the data until the next response.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= last_valid;
            if (last_valid) begin
                out_data <= last_data;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: DEPTH x DATA_W storage serving single-word reads
// and writes, read data returned after READ_LAT cycles with DataValid,
// illegal requests flagged on AccessError.
// Optional build macro MEM_INIT_CLEAR_EN: after reset the responder sweeps
// zeros through the whole array while holding Busy.
module mem_responder
    import mem_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEFAULT
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_responder_if.slave bus
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              in_range;
    logic              any_req;
    logic              rd_accept;
    logic              err_next;
    logic              access_error;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    assign req_idx = bus.Address[IDX_W-1:0];

`ifdef MEM_INIT_CLEAR_EN
    state_t           state, state_next;
    logic [IDX_W-1:0] clr_addr, clr_addr_next;

    // State register: reset always (re)starts the sweep at address 0.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Next state: step the sweep address, hand over to SERVE after the last word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == IDX_W'(DEPTH - 1)) begin
                    state_next = ST_SERVE;
                end else begin
                    clr_addr_next = clr_addr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    // Request decode: acceptance, read data selection and error classification.
    always_comb begin
        in_range  = addr_in_range(bus.Address);
        any_req   = bus.ReadEnable | bus.WriteEnable;
        rd_accept = bus.ReadEnable & ~bus.WriteEnable & ~busy;
        rd_data   = in_range ? mem[req_idx] : '0;
        if (busy) begin
            err_next = any_req;
        end else begin
            err_next = (bus.ReadEnable & bus.WriteEnable) | (any_req & ~in_range);
        end
    end

    // Write port select: the sweep owns the port while busy, otherwise the requester.
    always_comb begin
        mem_we    = bus.WriteEnable & in_range & ~busy;
        mem_waddr = req_idx;
        mem_wdata = bus.DataIN;
`ifdef MEM_INIT_CLEAR_EN
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    // Storage array write.
    always_ff @(posedge Clock) begin
        // NOTE: the array has no reset branch; contents survive reset and map onto plain RAM.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // One-cycle error pulse per offending request.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            access_error <= 1'b0;
        end else begin
            access_error <= err_next;
        end
    end

    mem_read_pipe #(
        .READ_LAT (READ_LAT)
    ) u_read_pipe (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (rd_accept),
        .in_data   (rd_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.DataOut     = pipe_data;
    assign bus.DataValid   = pipe_valid;
    assign bus.Busy        = busy;
    assign bus.AccessError = access_error;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with READ_LAT 1, 2, 3.
// Stimulus pushes expected read responses and per-cycle AccessError values;
// a forked monitor pops and compares at every falling edge.
// Honours MEM_INIT_CLEAR_EN when the RTL is built with it.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int N_DUT = 3;
`ifdef MEM_INIT_CLEAR_EN
    localparam int   BUSY_CYC = DEPTH;
    localparam logic BUSY_RST = 1'b1;
`else
    localparam int   BUSY_CYC = 0;
    localparam logic BUSY_RST = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] addr [N_DUT];
    logic [DATA_W-1:0] din  [N_DUT];
    logic [N_DUT-1:0]  re, we;
    logic [DATA_W-1:0] dout [N_DUT];
    logic [N_DUT-1:0]  dv, busy, aerr;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_responder_if bus_if ();
        assign bus_if.Address     = addr[g];
        assign bus_if.ReadEnable  = re[g];
        assign bus_if.WriteEnable = we[g];
        assign bus_if.DataIN      = din[g];
        assign dout[g] = bus_if.DataOut;
        assign dv[g]   = bus_if.DataValid;
        assign busy[g] = bus_if.Busy;
        assign aerr[g] = bus_if.AccessError;

        mem_responder #(
            .READ_LAT (g + 1)
        ) dut (
            .Clock (clk),
            .Reset (rst_n),
            .bus   (bus_if)
        );
    end

    rd_exp_t           rd_q  [N_DUT][$];
    bit                err_q [N_DUT][$];
    bit                p_rd  [N_DUT];
    bit                p_err [N_DUT];
    logic [DATA_W-1:0] p_data[N_DUT];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: the edge samples the request, expectations are queued,
    // then return at the falling edge with requests withdrawn.
    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < N_DUT; k++) begin
            if (p_rd[k]) rd_q[k].push_back('{data: p_data[k], cyc: cyc + k});
            err_q[k].push_back(p_err[k]);
        end
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            p_rd[k]  = 1'b0;
            p_err[k] = 1'b0;
            re[k]    = 1'b0;
            we[k]    = 1'b0;
        end
    endtask

    task automatic rd(input int k, input int a, input logic [DATA_W-1:0] exp_data);
        addr[k]   = ADDR_W'(a);
        re[k]     = 1'b1;
        p_rd[k]   = 1'b1;
        p_data[k] = exp_data;
        p_err[k]  = (a >= DEPTH);
    endtask

    // Read whose response must never appear (killed by a reset).
    task automatic rd_lost(input int k, input int a);
        addr[k] = ADDR_W'(a);
        re[k]   = 1'b1;
    endtask

    task automatic wr(input int k, input int a, input logic [DATA_W-1:0] d);
        addr[k]  = ADDR_W'(a);
        din[k]   = d;
        we[k]    = 1'b1;
        p_err[k] = (a >= DEPTH);
    endtask

    task automatic both(input int k, input int a, input logic [DATA_W-1:0] d);
        addr[k]  = ADDR_W'(a);
        din[k]   = d;
        re[k]    = 1'b1;
        we[k]    = 1'b1;
        p_err[k] = 1'b1;
    endtask

    task automatic do_reset(input int n);
        int busy_n;
        rst_n = 1'b0;
        repeat (n) tick();
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("rst_dout%0d", k), dout[k], '0);
            check($sformatf("rst_dv%0d", k), dv[k], 1'b0);
            check($sformatf("rst_busy%0d", k), busy[k], BUSY_RST);
        end
        rst_n = 1'b1;
        busy_n = 0;
        while (busy[0] && busy_n < 100) begin
            if (busy_n == 0) begin
                addr[0]  = '0;
                re[0]    = 1'b1;
                p_err[0] = 1'b1;
            end
            busy_n++;
            tick();
        end
        check("busy_cycles", busy_n, BUSY_CYC);
    endtask

    task automatic monitor();
        rd_exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                if (err_q[k].size() > 0)
                    check($sformatf("aerr%0d", k), aerr[k], err_q[k].pop_front());
                while (rd_q[k].size() > 0 && rd_q[k][0].cyc < cyc) begin
                    e = rd_q[k].pop_front();
                    check($sformatf("dv_missing%0d", k), cyc, e.cyc);
                end
                if (dv[k] === 1'b1) begin
                    if (rd_q[k].size() == 0) begin
                        check($sformatf("dv_unexpected%0d", k), dv[k], 1'b0);
                    end else begin
                        e = rd_q[k].pop_front();
                        check($sformatf("rd_data%0d", k), dout[k], e.data);
                        check($sformatf("rd_lat%0d", k), cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N_DUT; k++) begin
            addr[k] = '0;
            din[k]  = '0;
            re[k]   = 1'b0;
            we[k]   = 1'b0;
            p_rd[k] = 1'b0;
            p_err[k] = 1'b0;
            p_data[k] = '0;
        end
        fork
            monitor();
        join_none

        do_reset(2);

`ifdef MEM_INIT_CLEAR_EN
        rd(0, 31, 16'h0000);
        rd(2, 31, 16'h0000);
        tick();
        repeat (4) tick();
`endif

        // Write then read the same word next cycle (latency 1).
        wr(0, 3, 16'hA5A5); tick();
        rd(0, 3, 16'hA5A5); tick();
        tick();
        check("dout_hold", dout[0], 16'hA5A5);
        check("dv_drop", dv[0], 1'b0);

        // Back-to-back reads through the 3-deep pipe.
        wr(2, 0, 16'h0001); tick();
        wr(2, 1, 16'h0002); tick();
        wr(2, 2, 16'h0003); tick();
        rd(2, 0, 16'h0001); tick();
        rd(2, 1, 16'h0002); tick();
        rd(2, 2, 16'h0003); tick();
        repeat (4) tick();

        // Out-of-range accesses and the last legal word.
        wr(0, 8, 16'hBEEF);  tick();
        rd(0, 40, 16'h0000); tick();
        wr(0, 40, 16'hFFFF); tick();
        rd(0, 8, 16'hBEEF);  tick();
        rd(0, 63, 16'h0000); tick();
        wr(0, 31, 16'h7777); tick();
        rd(0, 32, 16'h0000); tick();
        rd(0, 31, 16'h7777); tick();
        repeat (2) tick();

        // Simultaneous read and write: write wins, no response.
        both(0, 5, 16'h1234); tick();
        rd(0, 5, 16'h1234);   tick();
        repeat (2) tick();

        // Latency-2 read, then a read killed by reset on the following edge.
        wr(1, 9, 16'h5555); tick();
        rd(1, 9, 16'h5555); tick();
        repeat (3) tick();
        rd_lost(1, 9); tick();
        do_reset(1);
        repeat (6) tick();

        @(posedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("rd_q_empty%0d", k), rd_q[k].size(), 0);
            check($sformatf("err_q_empty%0d", k), err_q[k].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
